// File: rtl/reset_sequencer.sv
// System reset controller: synchronised/debounced reset sources, hold timer,
// and ordered release of active-low reset domains with a sticky cause record.
//   state   | meaning
//   ASSERT  | all domains held in reset while any trigger is present
//   HOLD    | triggers clear, waiting HOLD_CYCLES before first release
//   RELEASE | releasing domains one by one, STAGE_GAP cycles apart
//   RUN     | all domains out of reset
module reset_sequencer #(
  parameter int NUM_SRC         = 2,
  parameter int NUM_OUTPUTS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   locked_in,
  input  logic [NUM_SRC-1:0]     req_in,
  output logic [NUM_OUTPUTS-1:0] reset_out,
  output logic                   active_out,
  output logic [NUM_SRC:0]       cause_out
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int STG_W  = $clog2(NUM_OUTPUTS + 1);

  typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_RELEASE, ST_RUN} state_t;

  // Bit 0 of each stage carries the PLL lock, bits NUM_SRC:1 the requests.
  logic [SYNC_STAGES-1:0][NUM_SRC:0] sync_q;
  logic                              lock_sync;
  logic [NUM_SRC-1:0]                req_sync;
  logic [NUM_SRC-1:0]                req_db;
  logic [DB_W-1:0]                   db_cnt [NUM_SRC];
  logic                              trigger;
  logic [NUM_SRC:0]                  cause_vec;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [STG_W-1:0]  stage;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {req_in, locked_in}};
    end
  end

  assign lock_sync = sync_q[SYNC_STAGES-1][0];
  assign req_sync  = sync_q[SYNC_STAGES-1][NUM_SRC:1];

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      req_db <= '0;
      for (int i = 0; i < NUM_SRC; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (req_sync[i] == req_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          req_db[i] <= ~req_db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign trigger   = ~lock_sync | (|req_db);
  assign cause_vec = {req_db, ~lock_sync};

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state      <= ST_ASSERT;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      stage      <= '0;
      reset_out  <= '0;
      active_out <= 1'b1;
      cause_out  <= '0;
    end else begin
      // Fresh record on entry to ASSERT, accumulate while staying there.
      if (state == ST_ASSERT) begin
        cause_out <= cause_out | cause_vec;
      end else if (trigger) begin
        cause_out <= cause_vec;
      end

      if (trigger) begin
        state      <= ST_ASSERT;
        reset_out  <= '0;
        active_out <= 1'b1;
        hold_cnt   <= '0;
        gap_cnt    <= '0;
        stage      <= '0;
      end else begin
        case (state)
          ST_ASSERT: begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
          ST_HOLD: begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
              hold_cnt  <= '0;
              reset_out <= NUM_OUTPUTS'(1);
              stage     <= '0;
              gap_cnt   <= '0;
              if (NUM_OUTPUTS == 1) begin
                state      <= ST_RUN;
                active_out <= 1'b0;
              end else begin
                state <= ST_RELEASE;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          ST_RELEASE: begin
            if (gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
              gap_cnt   <= '0;
              stage     <= stage + STG_W'(1);
              reset_out <= (reset_out << 1) | NUM_OUTPUTS'(1);
              if (int'(stage) + 1 == NUM_OUTPUTS - 1) begin
                state      <= ST_RUN;
                active_out <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          ST_RUN: begin
            state <= ST_RUN;
          end
          default: begin
            state <= ST_ASSERT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, glitch rejection, held request,
// lock loss mid-release, simultaneous sources and block reset in RUN.
module tb_reset_sequencer;

  logic       clk_in;
  logic       reset_in;
  logic       locked_in;
  logic [1:0] req_in;
  logic [2:0] reset_out;
  logic       active_out;
  logic [2:0] cause_out;

  int n_assert = 0;
  int n_fail   = 0;

  reset_sequencer #(
    .NUM_SRC(2),
    .NUM_OUTPUTS(3),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8),
    .STAGE_GAP(2)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .locked_in(locked_in),
    .req_in(req_in),
    .reset_out(reset_out),
    .active_out(active_out),
    .cause_out(cause_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks through a full release; hold_edge is the tick on which HOLD is entered.
  task automatic run_seq(input int hold_edge, input string tag);
    logic [2:0] exp;
    for (int t = 1; t <= hold_edge + 12; t++) begin
      tick();
      if (t < hold_edge + 8)       exp = 3'b000;
      else if (t < hold_edge + 10) exp = 3'b001;
      else if (t < hold_edge + 12) exp = 3'b011;
      else                         exp = 3'b111;
      check({tag, " reset_out"}, {5'b0, reset_out}, {5'b0, exp});
      check({tag, " active_out"}, {7'b0, active_out}, {7'b0, (exp != 3'b111)});
    end
  endtask

  initial begin
    logic [2:0] exp;

    reset_in  = 1'b0;
    locked_in = 1'b1;
    req_in    = 2'b00;
    repeat (3) tick();
    check("rst reset_out", {5'b0, reset_out}, 8'h00);
    check("rst active_out", {7'b0, active_out}, 8'h01);
    check("rst cause_out", {5'b0, cause_out}, 8'h00);

    // Power-up
    reset_in = 1'b1;
    run_seq(3, "powerup");
    check("powerup cause", {5'b0, cause_out}, 8'h01);

    // Three-cycle request glitch is filtered
    req_in = 2'b01;
    repeat (3) begin
      tick();
      check("glitch reset_out", {5'b0, reset_out}, 8'h07);
    end
    req_in = 2'b00;
    repeat (10) begin
      tick();
      check("glitch reset_out", {5'b0, reset_out}, 8'h07);
    end
    check("glitch cause", {5'b0, cause_out}, 8'h01);

    // Held request on req_in[1]
    req_in = 2'b10;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp = (t < 7) ? 3'b111 : 3'b000;
      check("held reset_out", {5'b0, reset_out}, {5'b0, exp});
    end
    check("held cause", {5'b0, cause_out}, 8'h04);
    req_in = 2'b00;
    run_seq(7, "held_restart");
    check("held cause after", {5'b0, cause_out}, 8'h04);

    // Single-cycle lock dropout still triggers, then lock loss in RELEASE
    locked_in = 1'b0;
    tick();
    check("lockpulse t1", {5'b0, reset_out}, 8'h07);
    locked_in = 1'b1;
    for (int t = 2; t <= 12; t++) begin
      tick();
      if (t < 3)       exp = 3'b111;
      else if (t < 12) exp = 3'b000;
      else             exp = 3'b001;
      check("lockpulse reset_out", {5'b0, reset_out}, {5'b0, exp});
    end
    check("lockpulse cause", {5'b0, cause_out}, 8'h01);
    locked_in = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 1)      exp = 3'b001;
      else if (t == 2) exp = 3'b011;
      else             exp = 3'b000;
      check("lockloss reset_out", {5'b0, reset_out}, {5'b0, exp});
    end
    locked_in = 1'b1;
    run_seq(3, "lockloss_restart");
    check("lockloss cause", {5'b0, cause_out}, 8'h01);

    // Simultaneous lock loss and req_in[0]
    locked_in = 1'b0;
    req_in    = 2'b01;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp = (t < 3) ? 3'b111 : 3'b000;
      check("simul reset_out", {5'b0, reset_out}, {5'b0, exp});
      if (t == 3) check("simul cause t3", {5'b0, cause_out}, 8'h01);
      if (t == 6) check("simul cause t6", {5'b0, cause_out}, 8'h01);
      if (t == 7) check("simul cause t7", {5'b0, cause_out}, 8'h03);
    end
    locked_in = 1'b1;
    req_in    = 2'b00;
    run_seq(7, "simul_restart");
    check("simul cause after", {5'b0, cause_out}, 8'h03);

    // Block reset while in RUN
    reset_in = 1'b0;
    tick();
    check("blkrst reset_out", {5'b0, reset_out}, 8'h00);
    check("blkrst active_out", {7'b0, active_out}, 8'h01);
    check("blkrst cause", {5'b0, cause_out}, 8'h00);
    reset_in = 1'b1;
    run_seq(3, "blkrst_restart");
    check("blkrst cause after", {5'b0, cause_out}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised system reset controller that replaces the single-button, single-lock reset expression in the board top level. It synchronises and debounces `NUM_SRC` asynchronous reset request inputs plus the PLL lock signal, holds reset for a programmable time after all sources clear, and then releases `NUM_OUTPUTS` active-low reset domains in order, spaced `STAGE_GAP` cycles apart. It also records which source caused the most recent reset.

## Interface
- `NUM_SRC`, 2: number of asynchronous active-high reset request inputs (buttons); ≥1.
- `NUM_OUTPUTS`, 3: number of sequenced reset domains; ≥1.
- `SYNC_STAGES`, 2: flip-flop stages per synchroniser; ≥2.
- `DEBOUNCE_CYCLES`, 10000: cycles a synchronised request must differ from its debounced value before the debounced value flips; ≥1.
- `HOLD_CYCLES`, 16: cycles spent in HOLD after all triggers clear; ≥1.
- `STAGE_GAP`, 4: cycles between consecutive domain releases; ≥1.

Ports:
- `clk_in`  in  1  single clock; all logic is on the rising edge.
- `reset_in`  in  1  synchronous, active-low reset of this block.
- `locked_in`  in  1  PLL lock, asynchronous; high = locked.
- `req_in`  in  NUM_SRC  asynchronous reset requests; high = pressed.
- `reset_out`  out  NUM_OUTPUTS  active-low domain resets; bit 0 is released first.
- `active_out`  out  1  high while any `reset_out` bit is low.
- `cause_out`  out  NUM_SRC+1  sticky cause. Bit 0 = lock loss. Bit i+1 = `req_in[i]`.

## Operation
- Each of the `NUM_SRC+1` inputs passes through a `SYNC_STAGES`-deep synchroniser. All synchroniser flops reset to 0.
- Debounce per request channel:
  - The counter clears whenever sync == debounced.
  - The counter increments whenever sync != debounced.
  - When the count reaches `DEBOUNCE_CYCLES-1` while the two still differ, the debounced value flips and the counter clears.
  - Debounced values reset to 0.
  - The lock signal is synchronised but not debounced.
- `trigger` = (lock_sync == 0) OR (any debounced request == 1). It is combinational from registers.
- FSM states: ASSERT, HOLD, RELEASE, RUN. The reset state is ASSERT.
  - **Any state** with trigger → ASSERT. This has priority over all other transitions.
  - **ASSERT**: all `reset_out` = 0. Stay while trigger is high. When trigger is low → HOLD with count = 0.
  - **HOLD**: count increments each cycle. At count == `HOLD_CYCLES-1` → RELEASE with stage = 0, and `reset_out[0]` goes to 1 on the same edge.
  - **RELEASE**: a gap counter runs 0..`STAGE_GAP-1`. At the end of each gap, stage increments and `reset_out[stage]` goes to 1. Releasing the last bit enters RUN.
  - When `NUM_OUTPUTS` = 1, HOLD goes directly to RUN.
  - **RUN**: all outputs high. Stay until trigger.
- `reset_out` and `active_out` are registered and update on the same edge as the state transition.
- `cause_out` behaviour:
  - On the edge entering ASSERT from another state, load {debounced requests, ~lock_sync}.
  - While in ASSERT, OR in the same vector every cycle.
  - Hold the value otherwise.
- Counter widths are `$clog2(max+1)` of their respective parameter. Counters never wrap because they clear on reaching their terminal value.
- `reset_in` low, effective on the next edge:
  - State becomes ASSERT.
  - `reset_out` = all 0, `active_out` = 1, `cause_out` = 0.
  - All synchronisers, debouncers and counters clear.
  - This applies mid-sequence as well.

## Timing
- Request to reset assertion: `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 edges after the first rising edge that samples `req_in` high.
- Lock loss to reset assertion: `SYNC_STAGES` + 1 edges.
- Trigger clear to first release: 1 edge into HOLD, plus `HOLD_CYCLES` edges.
- `reset_out[k]` rises `k*STAGE_GAP` edges after `reset_out[0]`. `active_out` falls on the same edge as `reset_out[NUM_OUTPUTS-1]`.
- Edge-detection rules:
  - A request pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles is ignored.
  - Any lock-low pulse that survives synchronisation triggers a reset.
- Simultaneous sources are all recorded in `cause_out`.
- A new trigger during HOLD or RELEASE drops every `reset_out` to 0 on the next edge and restarts the full sequence.

## Test plan
Bench parameters for all scenarios: NUM_SRC=2, NUM_OUTPUTS=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, STAGE_GAP=2. Edge E0 is the first edge at which `reset_in` is sampled high.

1. **Power-up.** `reset_in` low for 3 cycles, `locked_in`=1 throughout, `req_in`=0 → lock_sync high after E1; HOLD from E2; `reset_out` = 3'b001 at E10, 3'b011 at E12, 3'b111 at E14; `active_out` falls at E14; `cause_out`=3'b001.
2. **Glitch rejection.** In RUN, `req_in[0]` high for 3 cycles → `reset_out` stays 3'b111 and `cause_out` is unchanged.
3. **Held request.** In RUN, `req_in[1]` high for 20 cycles → `reset_out`=0 at 7 edges after the first high sample; outputs stay 0 while the request is held; after release and debounce the full sequence repeats; `cause_out`=3'b100.
4. **Lock loss mid-RELEASE.** Lock drops when `reset_out`=3'b001 → `reset_out`=0 at 3 edges after the drop; the sequence restarts after lock returns; `cause_out`=3'b001.
5. **Simultaneous sources.** `locked_in` drops and `req_in[0]` is held simultaneously → `cause_out`=3'b011.
6. **Block reset in RUN.** `reset_in` low for 1 cycle in RUN → next edge: `reset_out`=0, `active_out`=1, `cause_out`=0; then the power-up sequence of scenario 1 repeats.
